// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : 640x480@60 timing constants, RGB565 field widths and the
//                default coordinate width shared by the VGA capture path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    // Horizontal timing in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = 800;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = 525;

    // RGB565 pixel layout {r,g,b}
    localparam int VGA_R_W   = 5;
    localparam int VGA_G_W   = 6;
    localparam int VGA_B_W   = 5;
    localparam int VGA_PIX_W = VGA_R_W + VGA_G_W + VGA_B_W;

    // Coordinate / counter width and lock qualification depth
    localparam int VGA_CW          = 12;
    localparam int VGA_LOCK_FRAMES = 2;

endpackage

`default_nettype wire

// File: rtl/vga_rx_lock.sv
// ============================================================================
//  Module      : vga_rx_lock
//  Description : Timing-stability tracker. Learns the first line length of
//                each frame, counts lines per frame and qualifies consecutive
//                clean frames into a registered lock indication.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rx_lock #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line_stb,
    input  logic [CW-1:0] len_in,
    input  logic          vs_edge,
    input  logic          sat,
    output logic          locked,
    output logic          drop
);

    localparam int                LCW        = $clog2(LOCK_FRAMES + 1);
    localparam logic [LCW-1:0]    C_LOCK_MAX = LCW'(LOCK_FRAMES);
    localparam logic [CW-1:0]     C_CNT_MAX  = '1;

    logic            r_first;
    logic            r_clean;
    logic            r_have_prev;
    logic [CW-1:0]   r_ref_len;
    logic [CW-1:0]   r_lines;
    logic [CW-1:0]   r_prev_total;
    logic [LCW-1:0]  r_lock_cnt;
    logic            r_locked;

    logic            w_mismatch;
    logic            w_clean_now;
    logic            w_frame_ok;
    logic [CW-1:0]   w_lines_now;
    logic [LCW-1:0]  w_lock_cnt_nxt;

    // Judge the current line and the frame that a vsync edge closes
    always_comb begin
        // the strobe coinciding with a vs edge still closes a line of the old frame
        w_mismatch  = line_stb && !r_first && (len_in != r_ref_len);
        drop        = w_mismatch || sat;
        w_lines_now = (line_stb && (r_lines != C_CNT_MAX)) ? r_lines + 1'b1 : r_lines;
        w_clean_now = r_clean && !drop;
        w_frame_ok  = w_clean_now && r_have_prev && (w_lines_now == r_prev_total);

        w_lock_cnt_nxt = r_lock_cnt;
        if (vs_edge) begin
            if (!w_frame_ok) begin
                w_lock_cnt_nxt = '0;
            end else if (r_lock_cnt != C_LOCK_MAX) begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            end
        end
        if (drop) begin
            w_lock_cnt_nxt = '0;
        end
    end

    // Per-frame reference, line count and lock qualification state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first      <= 1'b1;
            r_clean      <= 1'b1;
            r_have_prev  <= 1'b0;
            r_ref_len    <= '0;
            r_lines      <= '0;
            r_prev_total <= '0;
            r_lock_cnt   <= '0;
            r_locked     <= 1'b0;
        end else begin
            if (vs_edge) begin
                r_first      <= 1'b1;
                r_clean      <= 1'b1;
                r_lines      <= '0;
                r_prev_total <= w_lines_now;
                r_have_prev  <= 1'b1;
            end else begin
                if (line_stb && r_first) begin
                    r_ref_len <= len_in;
                    r_first   <= 1'b0;
                end
                r_lines <= w_lines_now;
                r_clean <= w_clean_now;
            end
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_lock_cnt_nxt == C_LOCK_MAX);
        end
    end

    assign locked = r_locked;

endmodule

`default_nettype wire

// File: rtl/vga_capture_rx.sv
// ============================================================================
//  Module      : vga_capture_rx
//  Description : VGA receiver. Registers hsync/vsync/RGB565, recovers pixel
//                coordinates from sync deassertion edges, tracks timing lock
//                and emits a pixel-write stream for a bitmap framebuffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_capture_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int CW          = VGA_CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vga_in_hs,
    input  logic                 vga_in_vs,
    input  logic [VGA_R_W-1:0]   vga_in_r,
    input  logic [VGA_G_W-1:0]   vga_in_g,
    input  logic [VGA_B_W-1:0]   vga_in_b,
    output logic [CW-1:0]        pixel_x,
    output logic [CW-1:0]        pixel_y,
    output logic [VGA_PIX_W-1:0] pix_data,
    output logic                 pix_valid,
    output logic                 frame_start,
    output logic                 locked,
    output logic [CW-1:0]        line_len
);

    localparam logic [CW-1:0] C_CNT_MAX = '1;
    localparam logic [CW-1:0] C_H_START = CW'(H_BACK);
    localparam logic [CW-1:0] C_H_END   = CW'(H_BACK + H_ACTIVE);
    localparam logic [CW-1:0] C_V_START = CW'(V_BACK);
    localparam logic [CW-1:0] C_V_END   = CW'(V_BACK + V_ACTIVE);

    logic                 r_hs1, r_hs2, r_vs1, r_vs2;
    logic [VGA_PIX_W-1:0] r_rgb1, r_rgb2;
    logic [CW-1:0]        r_h_cnt, r_v_cnt;

    logic                 w_hs_rise, w_vs_rise, w_sat, w_drop;
    logic                 w_active, w_valid;
    logic [CW-1:0]        w_line_meas, w_x, w_y;

    // Input stage plus one extra delay: syncs for edge detect, RGB to align with h_cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // idle syncs read as deasserted so release does not fake an edge
            r_hs1  <= 1'b1;
            r_hs2  <= 1'b1;
            r_vs1  <= 1'b1;
            r_vs2  <= 1'b1;
            r_rgb1 <= '0;
            r_rgb2 <= '0;
        end else begin
            r_hs1  <= vga_in_hs;
            r_hs2  <= r_hs1;
            r_vs1  <= vga_in_vs;
            r_vs2  <= r_vs1;
            r_rgb1 <= {vga_in_r, vga_in_g, vga_in_b};
            r_rgb2 <= r_rgb1;
        end
    end

    // Sync deassert edges, measured line length, window decode and coordinates
    always_comb begin
        w_hs_rise   = r_hs1 && !r_hs2;
        w_vs_rise   = r_vs1 && !r_vs2;
        w_sat       = (r_h_cnt == C_CNT_MAX);
        w_line_meas = w_sat ? C_CNT_MAX : r_h_cnt + 1'b1;
        w_active    = (r_h_cnt >= C_H_START) && (r_h_cnt < C_H_END) &&
                      (r_v_cnt >= C_V_START) && (r_v_cnt < C_V_END);
        w_x         = r_h_cnt - C_H_START;
        w_y         = r_v_cnt - C_V_START;
        // a drop detected this cycle gates the strobe before locked itself falls
        w_valid     = locked && !w_drop && w_active;
    end

    // Saturating h/v position counters; h_cnt indexes the sample held in r_rgb2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            line_len <= '0;
        end else begin
            if (w_hs_rise) begin
                r_h_cnt  <= '0;
                line_len <= w_line_meas;
            end else if (!w_sat) begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
            if (w_vs_rise) begin
                r_v_cnt <= '0;
            end else if (w_hs_rise && (r_v_cnt != C_CNT_MAX)) begin
                r_v_cnt <= r_v_cnt + 1'b1;
            end
        end
    end

    // Pixel-write stream; data and coordinates hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_data    <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            pix_valid   <= w_valid;
            frame_start <= w_valid && (w_x == '0) && (w_y == '0);
            if (w_valid) begin
                pix_data <= r_rgb2;
                pixel_x  <= w_x;
                pixel_y  <= w_y;
            end
        end
    end

    vga_rx_lock #(
        .CW          (CW),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_stb (w_hs_rise),
        .len_in   (w_line_meas),
        .vs_edge  (w_vs_rise),
        .sat      (w_sat),
        .locked   (locked),
        .drop     (w_drop)
    );

endmodule

`default_nettype wire

// File: tb/tb_vga_capture_rx.sv
// ============================================================================
//  Module      : tb_vga_capture_rx
//  Description : Directed self-checking bench for vga_capture_rx using a
//                reduced raster (15 clocks x 8 lines, 8x4 active).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_capture_rx;

    localparam int H_ACTIVE = 8;
    localparam int H_BACK   = 3;
    localparam int H_SYNC   = 2;
    localparam int H_TOT    = 15;
    localparam int V_ACTIVE = 4;
    localparam int V_BACK   = 2;
    localparam int V_SYNC   = 1;
    localparam int V_TOT    = 8;
    localparam int CW       = 12;
    localparam int NPIX     = H_ACTIVE * V_ACTIVE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs = 1'b1;
    logic          vs = 1'b1;
    logic [4:0]    r = '0;
    logic [5:0]    g = '0;
    logic [4:0]    b = '0;
    logic [CW-1:0] pixel_x, pixel_y, line_len;
    logic [15:0]   pix_data;
    logic          pix_valid, frame_start, locked;

    int            total = 0;
    int            bad = 0;
    int            nv, nfs, drop_i;
    logic          exp_lock = 1'b0;
    logic          d_v [0:2];
    int            d_x [0:2];
    int            d_y [0:2];
    logic [15:0]   d_d [0:2];
    int            hold_x = 0, hold_y = 0;
    logic [15:0]   hold_d = '0;

    always #5 clk = ~clk;

    vga_capture_rx #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BACK      (H_BACK),
        .V_BACK      (V_BACK),
        .LOCK_FRAMES (2),
        .CW          (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_in_hs   (hs),
        .vga_in_vs   (vs),
        .vga_in_r    (r),
        .vga_in_g    (g),
        .vga_in_b    (b),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .line_len    (line_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int x, input int y);
        logic [9:0] xv;
        logic [5:0] yv;
        xv = 10'(x);
        yv = 6'(y);
        return {xv[4:0], yv, xv[9:5]};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_x"},     pixel_x,     0);
        check({tag, "_pixel_y"},     pixel_y,     0);
        check({tag, "_pix_data"},    pix_data,    0);
        check({tag, "_pix_valid"},   pix_valid,   0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_locked"},      locked,      0);
        check({tag, "_line_len"},    line_len,    0);
    endtask

    // one pixel clock: drive inputs, then check the output due from two edges earlier
    task automatic cyc(input logic h, input logic v, input logic [15:0] rgb,
                       input logic act, input int x, input int y);
        hs = h;
        vs = v;
        {r, g, b} = rgb;
        for (int i = 2; i > 0; i--) begin
            d_v[i] = d_v[i-1];
            d_x[i] = d_x[i-1];
            d_y[i] = d_y[i-1];
            d_d[i] = d_d[i-1];
        end
        d_v[0] = exp_lock & act;
        d_x[0] = x;
        d_y[0] = y;
        d_d[0] = rgb;
        @(posedge clk);
        #1;
        if (pix_valid === 1'b1) nv++;
        if (frame_start === 1'b1) nfs++;
        if (d_v[2]) begin
            hold_x = d_x[2];
            hold_y = d_y[2];
            hold_d = d_d[2];
        end
        check("pix_valid", pix_valid, d_v[2]);
        check("frame_start", frame_start, d_v[2] && d_x[2] == 0 && d_y[2] == 0);
        check("pixel_x", pixel_x, hold_x);
        check("pixel_y", pixel_y, hold_y);
        check("pix_data", pix_data, hold_d);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midline_reset");
        for (int i = 0; i < 3; i++) d_v[i] = 1'b0;
        hold_x   = 0;
        hold_y   = 0;
        hold_d   = '0;
        exp_lock = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    // lines first_j..V_TOT-1 of one frame; lk0/lk1 = locked after the vs edge and one cycle later
    task automatic frame(input int first_j, input logic lk0, input logic lk1, input int short_j,
                         input int rst_j, input int exp_nv, input int exp_fs);
        logic a, h, v;
        nv       = 0;
        nfs      = 0;
        exp_lock = lk1;
        for (int j = first_j; j < V_TOT; j++) begin
            for (int k = 0; k < H_TOT; k++) begin
                if (j == short_j && k == H_TOT - H_SYNC - 1) continue;
                if (short_j >= 0 && j == short_j + 1 && k == 0) exp_lock = 1'b0;
                h = (k < H_TOT - H_SYNC);
                v = (j < V_TOT - V_SYNC);
                a = (j >= V_BACK) && (j < V_BACK + V_ACTIVE) &&
                    (k >= H_BACK) && (k < H_BACK + H_ACTIVE);
                cyc(h, v, a ? pat(k - H_BACK, j - V_BACK) : 16'hFFFF, a, k - H_BACK, j - V_BACK);
                if (j == 0 && k == 0) check("locked_at_vs_edge", locked, lk0);
                if (j == 0 && k == 1) check("locked_after_vs_edge", locked, lk1);
                if (short_j >= 0 && j == short_j + 1 && k == 0) check("locked_before_drop", locked, 1);
                if (short_j >= 0 && j == short_j + 1 && k == 1) begin
                    check("locked_dropped", locked, 0);
                    check("line_len_short", line_len, H_TOT - 1);
                end
                if (j == rst_j && k == 6) pulse_reset();
            end
        end
        check("valid_per_frame", nv, exp_nv);
        check("frame_start_count", nfs, exp_fs);
    endtask

    // partial vsync line then four frames: lock appears one cycle after the 4th vs edge
    task automatic lock_up();
        frame(V_TOT - V_SYNC, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 1, -1, -1, NPIX, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            d_v[i] = 1'b0;
            d_x[i] = 0;
            d_y[i] = 0;
            d_d[i] = '0;
        end

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            hs = 1'($urandom);
            vs = 1'($urandom);
            {r, g, b} = 16'($urandom);
            @(posedge clk);
            #1;
        end
        check_all_zero("reset");

        // release with idle syncs: nothing may lock
        hs = 1'b1;
        vs = 1'b1;
        {r, g, b} = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);
        check("idle_locked", locked, 0);

        // power-up lock and first locked frame
        lock_up();
        check("line_len", line_len, H_TOT);

        // one short line in active line 3 while locked, then relock
        frame(0, 1, 1, 3, -1, 2 * H_ACTIVE, 1);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 1, -1, -1, NPIX, 1);
        check("line_len_relock", line_len, H_TOT);

        // hsync stuck low (vsync held low too): h_cnt runs to 4095 and lock is lost
        check("locked_before_hold", locked, 1);
        exp_lock = 1'b0;
        nv = 0;
        drop_i = -1;
        for (int i = 0; i < 5000; i++) begin
            cyc(1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 0);
            if (locked === 1'b0) begin
                drop_i = i;
                break;
            end
        end
        check("sat_drop_cycle", drop_i, 4082);
        check("sat_no_valid", nv, 0);

        // relock, then asynchronous reset pulse in the middle of active line 3
        lock_up();
        frame(0, 1, 1, -1, 3, H_ACTIVE + 2, 1);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 0, -1, -1, 0, 0);
        frame(0, 0, 1, -1, -1, NPIX, 1);
        check("line_len_after_reset", line_len, H_TOT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_capture_rx.md
Name: vga_capture_rx

Overview:
- Receiving end of the VGA link: samples incoming hsync/vsync and RGB565 on the 25 MHz pixel clock.
- Recovers pixel_x/pixel_y from sync edges, checks timing stability (lock), and emits a pixel-write stream for a bitmap framebuffer.
- Mirror of vga_core plus bitmap output: consumes the same signals vga_core/bitmap_gen produce.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BACK, 48, clocks from hsync deassertion to first active pixel
- V_BACK, 33, hsync deassertions from vsync deassertion to first active line
- LOCK_FRAMES, 2, consecutive clean frames required for lock
- CW, 12, coordinate/counter width

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- vga_in_hs  in  1  hsync, active-low
- vga_in_vs  in  1  vsync, active-low
- vga_in_r  in  5  red
- vga_in_g  in  6  green
- vga_in_b  in  5  blue
- pixel_x  out  CW  column of pix_data
- pixel_y  out  CW  row of pix_data
- pix_data  out  16  {r,g,b}
- pix_valid  out  1  write strobe, one per active pixel
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  timing stable
- line_len  out  CW  last measured clocks per line

Behaviour:
- Reset: async on rst_n low; all outputs 0, all counters 0, lock counter 0. Mid-frame reset aborts the frame; full relock sequence required.
- Input stage: all vga_in_* registered once (stage 1); sync delayed once more for edge detect. Deassert edge = registered sync 0->1.
- h_cnt: set to 0 on the cycle stage 1 first holds hs=1; otherwise increments, saturating at 2^CW-1.
- Input sample captured on the first clock edge with hs high has h index 0.
- v_cnt: 0 on vs deassert edge; +1 on each hs deassert edge, saturating. vs and hs edges in the same cycle: vs wins (v_cnt<=0).
- Active region: H_BACK <= h < H_BACK+H_ACTIVE and V_BACK <= v_cnt < V_BACK+V_ACTIVE.
- pixel_x = h-H_BACK; pixel_y = v_cnt-V_BACK.
- Latency: pixel presented at input edge N appears on pix_data/pix_valid after edge N+2.
- line_len: h_cnt+1 latched at each hs deassert edge (800 for standard timing).
- Frame clean: every line_len in the frame equals the first line_len of that frame, and the total line count equals the previous frame's total.
- At each vs deassert edge:
  - clean -> lock_cnt++ (saturate at LOCK_FRAMES).
  - not clean -> lock_cnt=0.
  - The first frame after reset only stores its total and is not clean.
- locked = (lock_cnt==LOCK_FRAMES); registered, rises the cycle after the qualifying vs edge.
- Loss of lock, effective cycle after detection:
  - line_len mismatch, or
  - h_cnt saturation (sync lost).
  - On either: locked=0, lock_cnt=0, pix_valid gated off immediately.
- pix_valid = locked & active. frame_start = pix_valid & x==0 & y==0.
- pix_data/pixel_x/pixel_y hold their last value when pix_valid=0.

Decomposition:
- Shared package vga_pkg: 640x480 timing constants (H/V active, porches, sync widths, totals 800/525), RGB565 field widths, CW.
- One sub-module: vga_rx_lock. Inputs are line_len strobe, vs edge and saturation flag; it maintains the reference line length, previous frame total and lock_cnt, and drives locked.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with no syncs -> locked stays 0.
- Standard 800x525 timing from a vga_core model, LOCK_FRAMES=2:
  - Response: locked rises 1 cycle after the 4th vs deassert edge.
  - Response: line_len=800.
- Pattern check with locked, driving pixel {x[4:0],y[5:0],x[9:5]}:
  - Exactly 307200 pix_valid per frame.
  - Each pix_data matches its (pixel_x,pixel_y).
  - Pixel (0,0) arrives 2 cycles after presentation, with frame_start=1 once.
- One line shortened to 799 clocks while locked:
  - locked=0 one cycle after that hs edge; pix_valid stays 0 thereafter.
  - locked returns after the glitched frame ends plus 2 clean frames.
- Hold hs low while locked -> locked drops once h_cnt reaches 4095; no pix_valid.
- Pulse rst_n low mid-active-line -> outputs 0 asynchronously; relock takes the same 4 vs edges as at power-up.
